// File: rtl/caesar_cg_pkg.sv
// Shared types and widths for the Caesar clock-gate controller.
package caesar_cg_pkg;

    typedef enum logic [1:0] {
        CG_ON   = 2'd0,
        CG_OFF  = 2'd1,
        CG_WAKE = 2'd2
    } cg_state_e;

    localparam int CG_WAKE_CNT_W  = 4;
    localparam int CG_GATED_CNT_W = 32;
    localparam int CG_WAKE_EVT_W  = 16;

endpackage

// File: rtl/caesar_clk_gate_ctrl.sv
// Idle-detect enable generator for the Caesar clock-gate cell, with a fixed settle period on wake.
// Optional statistics counters are built when CAESAR_CG_STATS_EN is defined.
//
// state   | meaning
// CG_ON   | clock running, counting consecutive idle cycles, grants allowed
// CG_OFF  | clock gated, waiting for req/busy/force_on
// CG_WAKE | clock reopened, settling; grants held off, cannot be aborted
module caesar_clk_gate_ctrl
    import caesar_cg_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  busy_i,
    input  logic                  req_i,
    input  logic                  force_on_i,
    output logic                  gnt_o,
    output logic                  clk_en_o,
`ifdef CAESAR_CG_STATS_EN
    output logic [31:0]           gated_cycles_o,
    output logic [15:0]           wake_cnt_o,
`endif
    output logic                  gated_o
);

    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15) begin : g_bad_wake_cycles
        $error("caesar_clk_gate_ctrl: WAKE_CYCLES must be in 1..15");
    end

    localparam logic [CG_WAKE_CNT_W-1:0] WAKE_LOAD = CG_WAKE_CNT_W'(WAKE_CYCLES - 1);

    cg_state_e               state, state_nxt;
    logic [IDLE_CNT_W-1:0]    idle_cnt, idle_nxt;
    logic [CG_WAKE_CNT_W-1:0] wake_cnt, wake_nxt;
    logic [IDLE_CNT_W:0]      idle_inc;
    logic                     idle;

    assign idle     = !busy_i && !req_i && !force_on_i;
    // One bit wider so the +1 cannot wrap when idle_cnt is saturated.
    assign idle_inc = {1'b0, idle_cnt} + (IDLE_CNT_W + 1)'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= CG_ON;
            idle_cnt <= '0;
            wake_cnt <= '0;
            clk_en_o <= 1'b1;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
            clk_en_o <= (state_nxt != CG_OFF);
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        case (state)
            CG_ON: begin
                if (!idle) begin
                    idle_nxt = '0;
                end else if (idle_thr_i != '0 && idle_inc >= {1'b0, idle_thr_i}) begin
                    state_nxt = CG_OFF;
                    idle_nxt  = '0;
                end else if (idle_cnt != '1) begin
                    idle_nxt = idle_cnt + IDLE_CNT_W'(1);
                end
            end
            CG_OFF: begin
                idle_nxt = '0;
                if (req_i || busy_i || force_on_i) begin
                    state_nxt = CG_WAKE;
                    wake_nxt  = WAKE_LOAD;
                end
            end
            CG_WAKE: begin
                idle_nxt = '0;
                if (wake_cnt == '0) begin
                    state_nxt = CG_ON;
                end else begin
                    wake_nxt = wake_cnt - CG_WAKE_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = CG_ON;
                idle_nxt  = '0;
                wake_nxt  = '0;
            end
        endcase
    end

    assign gnt_o   = req_i && (state == CG_ON);
    assign gated_o = (state == CG_OFF);

`ifdef CAESAR_CG_STATS_EN
    logic [CG_GATED_CNT_W-1:0] gated_cycles;
    logic [CG_WAKE_EVT_W-1:0]  wake_evts;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gated_cycles <= '0;
            wake_evts    <= '0;
        end else begin
            if (state == CG_OFF && gated_cycles != '1) begin
                gated_cycles <= gated_cycles + CG_GATED_CNT_W'(1);
            end
            if (state == CG_OFF && state_nxt == CG_WAKE && wake_evts != '1) begin
                wake_evts <= wake_evts + CG_WAKE_EVT_W'(1);
            end
        end
    end

    assign gated_cycles_o = gated_cycles;
    assign wake_cnt_o     = wake_evts;
`endif

endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
// Directed self-checking bench for caesar_clk_gate_ctrl (WAKE_CYCLES = 4, IDLE_CNT_W = 8).
module tb_caesar_clk_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] idle_thr_i;
    logic       busy_i, req_i, force_on_i;
    logic       gnt_o, clk_en_o, gated_o;
`ifdef CAESAR_CG_STATS_EN
    logic [31:0] gated_cycles_o;
    logic [15:0] wake_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    caesar_clk_gate_ctrl #(.IDLE_CNT_W(8), .WAKE_CYCLES(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .idle_thr_i (idle_thr_i),
        .busy_i     (busy_i),
        .req_i      (req_i),
        .force_on_i (force_on_i),
        .gnt_o      (gnt_o),
        .clk_en_o   (clk_en_o),
`ifdef CAESAR_CG_STATS_EN
        .gated_cycles_o (gated_cycles_o),
        .wake_cnt_o     (wake_cnt_o),
`endif
        .gated_o    (gated_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni     = 1'b0;
        idle_thr_i = 8'd3;
        busy_i     = 1'b0;
        req_i      = 1'b0;
        force_on_i = 1'b0;

        // Reset values
        repeat (2) cyc();
        chk("rst_clk_en", clk_en_o, 1);
        chk("rst_gated", gated_o, 0);
        chk("rst_gnt", gnt_o, 0);

        // Gating with threshold 3: enable falls at the 3rd edge after release
        rst_ni = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk($sformatf("gate3_clk_en_e%0d", i), clk_en_o, (i < 3) ? 1 : 0);
            chk($sformatf("gate3_gated_e%0d", i), gated_o, (i < 3) ? 0 : 1);
        end
        cyc();
        chk("gate3_stays_off", clk_en_o, 0);

        // Wake by request: gnt exactly 5 cycles after the request cycle
        req_i = 1'b1;
        #1;
        chk("wake_gnt_t0", gnt_o, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            #1;
            chk($sformatf("wake_clk_en_c%0d", i), clk_en_o, 1);
            chk($sformatf("wake_gnt_c%0d", i), gnt_o, (i == 5) ? 1 : 0);
        end
        cyc();
        req_i = 1'b0;

        // Threshold 0: never gates
        idle_thr_i = 8'd0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            chk("thr0_clk_en", clk_en_o, 1);
            chk("thr0_gated", gated_o, 0);
        end

        // Request in the cycle the threshold would be reached keeps ON and grants
        idle_thr_i = 8'd3;
        busy_i     = 1'b1;
        cyc();
        busy_i = 1'b0;
        repeat (2) cyc();
        req_i = 1'b1;
        #1;
        chk("req_at_thr_gnt", gnt_o, 1);
        cyc();
        chk("req_at_thr_clk_en", clk_en_o, 1);
        chk("req_at_thr_gated", gated_o, 0);
        req_i = 1'b0;

        // Threshold lowered mid-count: idle_cnt 5 with thr 10, then thr 4
        idle_thr_i = 8'd10;
        busy_i     = 1'b1;
        cyc();
        busy_i = 1'b0;
        repeat (5) cyc();
        chk("lower_thr_before", clk_en_o, 1);
        idle_thr_i = 8'd4;
        cyc();
        chk("lower_thr_clk_en", clk_en_o, 0);
        chk("lower_thr_gated", gated_o, 1);

        // Async reset mid-OFF reopens the clock without a clock edge
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_off_clk_en", clk_en_o, 1);
        chk("rst_off_gated", gated_o, 0);
        cyc();
        rst_ni = 1'b1;
        // idle_cnt restarts from 0: threshold 4 gates at the 4th edge
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("post_rst_clk_en_e%0d", i), clk_en_o, (i < 4) ? 1 : 0);
        end

        // Async reset during WAKE with wake_cnt = 2
        force_on_i = 1'b1;
        cyc();
        force_on_i = 1'b0;
        chk("force_wake_clk_en", clk_en_o, 1);
        cyc();
        #1;
        chk("wake_hold_gnt", gnt_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("rst_wake_clk_en", clk_en_o, 1);
        chk("rst_wake_gated", gated_o, 0);
        chk("rst_wake_gnt", gnt_o, 0);
        cyc();
        rst_ni = 1'b1;
        req_i  = 1'b1;
        #1;
        chk("post_rst_wake_gnt", gnt_o, 1);
        cyc();
        req_i = 1'b0;

`ifdef CAESAR_CG_STATS_EN
        // Two gating episodes of 7 and 12 OFF cycles
        for (int e = 0; e < 2; e++) begin
            idle_thr_i = 8'd2;
            force_on_i = 1'b1;
            cyc();
            force_on_i = 1'b0;
            repeat (2) cyc();
            chk("stats_off_entry", gated_o, 1);
            idle_thr_i = 8'd0;
            repeat ((e == 0 ? 7 : 12) - 1) cyc();
            force_on_i = 1'b1;
            cyc();
            force_on_i = 1'b0;
            repeat (5) cyc();
        end
        chk("stats_gated_cycles", gated_cycles_o, 32'd19);
        chk("stats_wake_cnt", {16'd0, wake_cnt_o}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
